// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JUMP   = 2'd2,
      SEL_JR     = 2'd3
   } redir_sel_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INCR   = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready handshake between fetch (master) and memory (slave).
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Priority mux for the next PC: jump-register over jump over taken branch over sequential.
module next_pc_sel
   import fetch_pkg::*;
(
   input  logic [31:0] pc_plus_4,
   input  logic        pcsrcD,
   input  logic [31:0] branch_addr,
   input  logic        jumpD,
   input  logic [31:0] jump_addr,
   input  logic        jrD,
   input  logic [31:0] jr_addr,
   output logic [31:0] next_pc,
   output logic        redirect
);

   redir_sel_e sel_s;

   // Resolve which redirect source wins this cycle.
   always_comb begin
      sel_s = SEL_SEQ;
      if (jrD) begin
         sel_s = SEL_JR;
      end else if (jumpD) begin
         sel_s = SEL_JUMP;
      end else if (pcsrcD) begin
         sel_s = SEL_BRANCH;
      end else begin
         sel_s = SEL_SEQ;
      end
   end

   // Select the target; redirect targets are forced onto a word boundary.
   always_comb begin
      next_pc  = pc_plus_4;
      redirect = 1'b0;
      case (sel_s)
         SEL_JR: begin
            next_pc  = word_align(jr_addr);
            redirect = 1'b1;
         end
         SEL_JUMP: begin
            next_pc  = word_align(jump_addr);
            redirect = 1'b1;
         end
         SEL_BRANCH: begin
            next_pc  = word_align(branch_addr);
            redirect = 1'b1;
         end
         default: begin
            next_pc  = pc_plus_4;
            redirect = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, delivery to decode.
// Optional FETCH_DELAY_SLOT_EN keeps the redirect-cycle word valid as a MIPS delay slot.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stallF,
   input  logic         pcsrcD,
   input  logic [31:0]  branch_addr,
   input  logic         jumpD,
   input  logic [31:0]  jump_addr,
   input  logic         jrD,
   input  logic [31:0]  jr_addr,
   fetch_unit_if.master imem,
   output logic [31:0]  instr,
   output logic [31:0]  pc_plus_4,
   output logic         valid,
   output logic         fetch_busy
);

`ifdef FETCH_DELAY_SLOT_EN
   localparam logic DELAY_SLOT = 1'b1;
`else
   localparam logic DELAY_SLOT = 1'b0;
`endif

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc4_q, pc4_d;
   logic         valid_q, valid_d;
   logic [31:0]  hold_instr_q, hold_instr_d;
   logic [31:0]  hold_pc4_q, hold_pc4_d;
   logic         hold_valid_q, hold_valid_d;
   logic         hold_redir_q, hold_redir_d;
   logic         pend_q, pend_d;
   logic [31:0]  pend_tgt_q, pend_tgt_d;

   logic [31:0]  pc_seq_s;
   logic [31:0]  sel_pc_s;
   logic         redir_s;

   assign pc_seq_s = pc_q + PC_INCR;

   next_pc_sel u_next_pc_sel (
      .pc_plus_4   (pc_seq_s),
      .pcsrcD      (pcsrcD),
      .branch_addr (branch_addr),
      .jumpD       (jumpD),
      .jump_addr   (jump_addr),
      .jrD         (jrD),
      .jr_addr     (jr_addr),
      .next_pc     (sel_pc_s),
      .redirect    (redir_s)
   );

   // Next-state and datapath update for the fetch FSM.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc4_d   = hold_pc4_q;
      hold_valid_d = hold_valid_q;
      hold_redir_d = hold_redir_q;
      pend_d       = pend_q;
      pend_tgt_d   = pend_tgt_q;
      case (state_q)
         ST_RESET: begin
            state_d = ST_FETCH;
            if (redir_s) begin
               pc_d = sel_pc_s;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_FETCH: begin
            if (imem.imem_ready) begin
               pend_d = 1'b0;
               if (pend_q) begin
                  // Redirect arrived mid-handshake: drop the word, refetch at the target.
                  pc_d    = redir_s ? sel_pc_s : pend_tgt_q;
                  valid_d = (stallF && !redir_s) ? valid_q : 1'b0;
               end else if (stallF) begin
                  hold_instr_d = imem.imem_rdata;
                  hold_pc4_d   = pc_seq_s;
                  hold_valid_d = redir_s ? DELAY_SLOT : 1'b1;
                  hold_redir_d = redir_s;
                  pc_d         = redir_s ? sel_pc_s : pc_q;
                  valid_d      = redir_s ? 1'b0 : valid_q;
                  state_d      = ST_HOLD;
               end else begin
                  instr_d = imem.imem_rdata;
                  pc4_d   = pc_seq_s;
                  valid_d = redir_s ? DELAY_SLOT : 1'b1;
                  pc_d    = sel_pc_s;
               end
            end else begin
               if (redir_s) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = sel_pc_s;
               end else begin
                  pend_d = pend_q;
               end
               valid_d = (stallF && !redir_s) ? valid_q : 1'b0;
            end
         end
         ST_HOLD: begin
            if (stallF) begin
               if (redir_s) begin
                  pc_d         = sel_pc_s;
                  hold_redir_d = 1'b1;
                  hold_valid_d = hold_valid_q & DELAY_SLOT;
                  valid_d      = 1'b0;
               end else begin
                  pc_d = pc_q;
               end
            end else begin
               instr_d = hold_instr_q;
               pc4_d   = hold_pc4_q;
               state_d = ST_FETCH;
               if (redir_s) begin
                  pc_d    = sel_pc_s;
                  valid_d = hold_valid_q & DELAY_SLOT;
               end else begin
                  pc_d    = hold_redir_q ? pc_q : pc_seq_s;
                  valid_d = hold_valid_q;
               end
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RESET;
         pc_q         <= word_align(RESET_PC);
         instr_q      <= NOP_INSTR;
         pc4_q        <= 32'h0000_0000;
         valid_q      <= 1'b0;
         hold_instr_q <= NOP_INSTR;
         hold_pc4_q   <= 32'h0000_0000;
         hold_valid_q <= 1'b0;
         hold_redir_q <= 1'b0;
         pend_q       <= 1'b0;
         pend_tgt_q   <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc4_q   <= hold_pc4_d;
         hold_valid_q <= hold_valid_d;
         hold_redir_q <= hold_redir_d;
         pend_q       <= pend_d;
         pend_tgt_q   <= pend_tgt_d;
      end
   end

   assign imem.imem_req  = (state_q == ST_FETCH);
   assign imem.imem_addr = pc_q;
   assign fetch_busy     = imem.imem_req && !imem.imem_ready;
   assign instr          = instr_q;
   assign pc_plus_4      = pc4_q;
   assign valid          = valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage feeding the decode pipeline register. Holds the PC and drives a variable-latency instruction-memory request/ready handshake. Delivers `instr` and `pc_plus_4` with a valid flag to decode. Consumes the redirect signals decode produces (branch taken, jump, jump-register, each with a target address) and the hazard unit's fetch stall.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stallF` in 1: hazard-unit stall; hold the PC and the presented instruction.
- `pcsrcD` in 1: branch taken in decode.
- `branch_addr` in 32: branch target.
- `jumpD` in 1: jump in decode.
- `jump_addr` in 32: jump target.
- `jrD` in 1: jump-register in decode.
- `jr_addr` in 32: register target.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; word aligned, bits [1:0] = 0.
- `imem_ready` in 1: memory accepts the request and returns data this cycle.
- `imem_rdata` in 32: instruction word, valid when `imem_req && imem_ready`.
- `instr` out 32: instruction to decode register.
- `pc_plus_4` out 32: PC of `instr` + 4.
- `valid` out 1: `instr` is a real instruction; 0 means bubble (NOP).
- `fetch_busy` out 1: a request is outstanding and not yet answered; hazard unit ORs this into its stalls.

## Operation
- Redirect priority: `jrD` > `jumpD` > `pcsrcD`. A redirect is any of the three. Target bits [1:0] are forced to 0.
- FSM states:
  - RESET: entered by `reset`. Goes to FETCH next cycle.
  - FETCH: `imem_req`=1 with `imem_addr`=PC. Transitions:
    - `imem_ready`=1 and `stallF`=0: capture the word into `instr`, set `valid`=1, set PC=PC+4 (or the redirect target), stay in FETCH.
    - `imem_ready`=1 and `stallF`=1: capture into a hold buffer, go to HOLD.
    - `imem_ready`=0: stay in FETCH with address and request stable.
  - HOLD: `imem_req`=0; `instr` and `valid` unchanged. When `stallF` falls, present the buffered word, advance the PC, go to FETCH.
  - Redirect in any state: the PC loads the target.
    - An outstanding unanswered request is retargeted only after its handshake completes. The returned word is discarded and the state goes to FETCH at the target.
    - The `imem_addr` change is never made mid-handshake.
- Squash: without the delay-slot feature, the word fetched in the same cycle as a redirect is presented with `valid`=0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=32'h0, `pc_plus_4`=32'h0, `valid`=0, `fetch_busy`=0.
- The first request is asserted in the first cycle after `reset` deasserts.
- Latency: zero-wait memory (`imem_ready` tied high) gives one instruction per cycle. `instr` is registered and appears the cycle after the handshake.
- `fetch_busy` = `imem_req && !imem_ready`, combinational.
- Simultaneous redirect and `stallF`: the redirect wins for the PC. The presented instruction is held with `valid` forced to 0.
- `reset` mid-handshake aborts the request immediately. The next-cycle `imem_ready` is ignored.

## Configuration
- `FETCH_DELAY_SLOT_EN`
  - Defined: MIPS branch-delay-slot semantics. The word fetched in the redirect cycle is the delay slot and is presented with `valid`=1. The redirect target is fetched next.
  - Undefined: that word is squashed (`valid`=0), matching decode's clear-on-`pcsrc` behaviour.

## Structure
- Package `fetch_pkg`:
  - state enum (RESET, FETCH, HOLD)
  - `NOP_INSTR` = 32'h0000_0000
  - redirect-select encoding
- Sub-module `next_pc_sel`: combinational priority mux producing the next PC and a redirect flag from PC+4, `jrD`/`jumpD`/`pcsrcD` and their targets.

## Test plan
- Reset, then `imem_ready`=1 always, rdata = address: `imem_addr` sequence is 0x00400000, 0x00400004, 0x00400008. `instr` follows one cycle later with `valid`=1.
- `imem_ready` low for 3 cycles at 0x00400004: `imem_addr` is stable and `fetch_busy`=1 for 3 cycles. `instr`=0x00400004 is presented once.
- `stallF` high for 2 cycles after a handshake: state is HOLD, `imem_req`=0, `instr` unchanged. Fetch resumes at PC+4 after release.
- `pcsrcD`=1, `branch_addr`=0x00400100, asserted together with `jrD`=1, `jr_addr`=0x00400200: next fetch is 0x00400200. The same-cycle word has `valid`=0, or `valid`=1 with `FETCH_DELAY_SLOT_EN`.
- Redirect to 0x00400300 while a request is outstanding and `imem_ready` arrives 2 cycles later: the returned word is discarded and the next `imem_addr` is 0x00400300.
- `reset` asserted mid-handshake: all outputs return to their reset values the next cycle, and the first request after release is `RESET_PC`.
